// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and its alignment helper.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_BUSY = 2'b01,
    LS_BUSY = 2'b10,
    RESP    = 2'b11
  } state_e;

  // Load/store size encodings; any op with bit 1 clear is a word access.
  typedef enum logic [1:0] {
    LS_WORD     = 2'b00,
    LS_WORD_ALT = 2'b01,
    LS_HALF     = 2'b10,
    LS_BYTE     = 2'b11
  } ls_op_e;

  // Byte-enable patterns before lane shifting.
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  // Memory addresses are always word aligned on the shared port.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalignment
// detection for both requesters, and load data extraction/extension.
module lsu_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  req_op_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  if_addr_lo_i,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  output logic        ls_misal_o,
  output logic        if_misal_o,
  input  logic [1:0]  ld_op_i,
  input  logic        ld_un_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Request side: lane enables, replicated store data and alignment check.
  always_comb begin
    req_be_o    = BE_WORD;
    req_wdata_o = req_wdata_i;
    ls_misal_o  = 1'b0;
    if_misal_o  = (if_addr_lo_i != 2'b00);
    case (req_op_i)
      LS_HALF: begin
        req_be_o    = BE_HALF << {req_addr_lo_i[1], 1'b0};
        req_wdata_o = {2{req_wdata_i[15:0]}};
        ls_misal_o  = req_addr_lo_i[0];
      end
      LS_BYTE: begin
        req_be_o    = BE_BYTE << req_addr_lo_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
        ls_misal_o  = 1'b0;
      end
      default: begin
        req_be_o    = BE_WORD;
        req_wdata_o = req_wdata_i;
        ls_misal_o  = (req_addr_lo_i != 2'b00);
      end
    endcase
  end

  // Load side: pick the addressed lane and zero/sign extend it.
  always_comb begin
    ld_byte_s = ld_word_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half_s = ld_word_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
    ld_data_o = ld_word_i;
    case (ld_op_i)
      LS_HALF: ld_data_o = ld_un_i ? {16'h0000, ld_half_s} : {{16{ld_half_s[15]}}, ld_half_s};
      LS_BYTE: ld_data_o = ld_un_i ? {24'h000000, ld_byte_s} : {{24{ld_byte_s[7]}}, ld_byte_s};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single
// memory port with one outstanding transaction, fair alternation under
// contention, misalignment rejection and an ack timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_ls_req,
  input  logic        i_ls_wren,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [1:0]  i_ls_op,
  input  logic        i_ls_un,
  output logic        o_ls_ack,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_err,
  output logic        o_mem_req,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  // Last busy-cycle count value before the transaction is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic        last_ls_q, last_ls_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wren_q, mem_wren_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [1:0]  ld_op_q, ld_op_d;
  logic        ld_un_q, ld_un_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        if_ack_q, if_ack_d;
  logic        if_err_q, if_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        ls_ack_q, ls_ack_d;
  logic        ls_err_q, ls_err_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        busy_q, busy_d;

  logic        grant_ls_s, grant_if_s;
  logic [3:0]  req_be_s;
  logic [31:0] req_wdata_s;
  logic        ls_misal_s, if_misal_s;
  logic [31:0] ld_data_s;

  // Under contention the side that did not win last time gets the port.
  assign grant_ls_s = i_ls_req & (~i_if_req | ~last_ls_q);
  assign grant_if_s = i_if_req & ~grant_ls_s;

  lsu_align u_align (
    .req_op_i      (i_ls_op),
    .req_addr_lo_i (i_ls_addr[1:0]),
    .req_wdata_i   (i_ls_wdata),
    .if_addr_lo_i  (i_if_addr[1:0]),
    .req_be_o      (req_be_s),
    .req_wdata_o   (req_wdata_s),
    .ls_misal_o    (ls_misal_s),
    .if_misal_o    (if_misal_s),
    .ld_op_i       (ld_op_q),
    .ld_un_i       (ld_un_q),
    .ld_addr_lo_i  (ld_lo_q),
    .ld_word_i     (i_mem_rdata),
    .ld_data_o     (ld_data_s)
  );

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_wren_d  = mem_wren_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    ld_op_d     = ld_op_q;
    ld_un_d     = ld_un_q;
    ld_lo_d     = ld_lo_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_ack_d    = 1'b0;
    ls_err_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (grant_ls_s) begin
          last_ls_d = 1'b1;
          ld_op_d   = i_ls_op;
          ld_un_d   = i_ls_un;
          ld_lo_d   = i_ls_addr[1:0];
          if (ls_misal_s) begin
            state_d    = RESP;
            ls_ack_d   = 1'b1;
            ls_err_d   = 1'b1;
            ls_rdata_d = 32'h0000_0000;
          end else begin
            state_d     = LS_BUSY;
            mem_req_d   = 1'b1;
            mem_wren_d  = i_ls_wren;
            mem_addr_d  = word_align(i_ls_addr);
            mem_wdata_d = req_wdata_s;
            mem_be_d    = req_be_s;
          end
        end else if (grant_if_s) begin
          last_ls_d = 1'b0;
          if (if_misal_s) begin
            state_d    = RESP;
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = 32'h0000_0000;
          end else begin
            state_d     = IF_BUSY;
            mem_req_d   = 1'b1;
            mem_wren_d  = 1'b0;
            mem_addr_d  = word_align(i_if_addr);
            mem_wdata_d = 32'h0000_0000;
            mem_be_d    = BE_WORD;
          end
        end else begin
          state_d = IDLE;
        end
      end

      IF_BUSY, LS_BUSY: begin
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          cnt_d     = 8'd0;
          if (state_q == LS_BUSY) begin
            ls_ack_d = 1'b1;
            if (mem_wren_q) begin
              ls_rdata_d = 32'h0000_0000;
            end else begin
              ls_rdata_d = ld_data_s;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_mem_rdata;
          end
        end else if (cnt_q == TMO_LAST) begin
          // Memory never answered: abandon the access and report an error.
          mem_req_d = 1'b0;
          state_d   = RESP;
          cnt_d     = 8'd0;
          if (state_q == LS_BUSY) begin
            ls_ack_d   = 1'b1;
            ls_err_d   = 1'b1;
            ls_rdata_d = 32'h0000_0000;
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = 32'h0000_0000;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      last_ls_q   <= 1'b0;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      ld_op_q     <= 2'b00;
      ld_un_q     <= 1'b0;
      ld_lo_q     <= 2'b00;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      ls_ack_q    <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      ld_op_q     <= ld_op_d;
      ld_un_q     <= ld_un_d;
      ld_lo_q     <= ld_lo_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_ack_q    <= ls_ack_d;
      ls_err_q    <= ls_err_d;
      ls_rdata_q  <= ls_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_if_err    = if_err_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_ack    = ls_ack_q;
  assign o_ls_err    = ls_err_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_wren  = mem_wren_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;
  logic        o_if_err;
  logic        i_ls_req;
  logic        i_ls_wren;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [1:0]  i_ls_op;
  logic        i_ls_un;
  logic        o_ls_ack;
  logic [31:0] o_ls_rdata;
  logic        o_ls_err;
  logic        o_mem_req;
  logic        o_mem_wren;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
    .i_ls_req(i_ls_req), .i_ls_wren(i_ls_wren), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_op(i_ls_op), .i_ls_un(i_ls_un),
    .o_ls_ack(o_ls_ack), .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
    .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16];

  // Observations gathered by the memory responder for one transaction.
  int          obs_req_cycles;
  bit          obs_stable;
  bit          obs_timeout;
  logic        obs_if_ack, obs_ls_ack, obs_err, obs_wren;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Behaves as the memory: acks after 'lat' request cycles (never if lat>TMO),
  // injects ack noise while no request is outstanding, and records what it saw.
  task automatic service(input int lat, input bit keep);
    int n;
    logic [3:0] idx;
    n = 0;
    obs_req_cycles = 0; obs_stable = 1'b1; obs_timeout = 1'b1;
    obs_if_ack = 1'b0; obs_ls_ack = 1'b0; obs_err = 1'b0; obs_wren = 1'b0;
    obs_rdata = 32'h0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_be = 4'h0;
    while (obs_timeout && n < 64) begin
      tick();
      n++;
      i_mem_ack = 1'b0;
      i_mem_rdata = $urandom();
      if (o_if_ack || o_ls_ack) begin
        obs_if_ack = o_if_ack;
        obs_ls_ack = o_ls_ack;
        obs_err    = o_if_ack ? o_if_err : o_ls_err;
        obs_rdata  = o_if_ack ? o_if_rdata : o_ls_rdata;
        obs_timeout = 1'b0;
        i_mem_ack = 1'($urandom_range(0, 1));
        if (!keep) begin
          if (o_if_ack) i_if_req = 1'b0;
          if (o_ls_ack) i_ls_req = 1'b0;
        end
      end else if (o_mem_req) begin
        if (obs_req_cycles == 0) begin
          obs_addr = o_mem_addr; obs_be = o_mem_be;
          obs_wdata = o_mem_wdata; obs_wren = o_mem_wren;
        end else if (o_mem_addr !== obs_addr || o_mem_be !== obs_be ||
                     o_mem_wdata !== obs_wdata || o_mem_wren !== obs_wren) begin
          obs_stable = 1'b0;
        end
        obs_req_cycles++;
        if (obs_req_cycles == lat) begin
          idx = o_mem_addr[5:2];
          if (o_mem_wren) begin
            for (int b = 0; b < 4; b++) begin
              if (o_mem_be[b]) mem[idx][8*b +: 8] = o_mem_wdata[8*b +: 8];
            end
          end
          i_mem_rdata = mem[idx];
          i_mem_ack = 1'b1;
        end
      end else begin
        i_mem_ack = 1'($urandom_range(0, 1));
      end
    end
    if (obs_timeout) begin
      checks++; failures++;
      $display("FAIL service_bound: no ack within 64 cycles");
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_if_ack, o_if_rdata, o_if_err, o_ls_ack, o_ls_rdata, o_ls_err, o_mem_req,
         o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_be, o_busy} !== 139'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b mem_req=%b addr=%h, required all zero",
               o_busy, o_mem_req, o_mem_addr);
    end
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_if_read();
    i_mem_ack = 1'b0;
    i_if_addr = 32'h0000_0100;
    i_if_req = 1'b1;
    tick();
    checks++;
    if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_be, o_busy, o_if_ack} !==
        {1'b1, 1'b0, 32'h0000_0100, 4'b1111, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL if_issue: req=%b wren=%b addr=%h be=%b busy=%b ack=%b, required 1 0 00000100 1111 1 0",
               o_mem_req, o_mem_wren, o_mem_addr, o_mem_be, o_busy, o_if_ack);
    end
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({o_if_ack, o_if_rdata, o_if_err, o_mem_req, o_ls_ack} !==
        {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL if_ack: ack=%b rdata=%h err=%b mem_req=%b ls_ack=%b, required 1 deadbeef 0 0 0",
               o_if_ack, o_if_rdata, o_if_err, o_mem_req, o_ls_ack);
    end
    i_mem_ack = 1'b0;
    i_if_req = 1'b0;
    i_mem_rdata = 32'h1111_2222;
    tick();
    checks++;
    if ({o_if_ack, o_if_err, o_if_rdata, o_busy} !== {1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      failures++;
      $display("FAIL if_hold: ack=%b err=%b rdata=%h busy=%b, required 0 0 deadbeef 0",
               o_if_ack, o_if_err, o_if_rdata, o_busy);
    end
  endtask

  task automatic test_byte_load();
    mem[0] = 32'h80FF_FFFF;
    i_ls_wren = 1'b0; i_ls_op = 2'b11; i_ls_addr = 32'h0000_0203; i_ls_un = 1'b0;
    i_ls_req = 1'b1;
    service(1, 1'b0);
    checks++;
    if ({obs_ls_ack, obs_be, obs_rdata, obs_err} !== {1'b1, 4'b1000, 32'hFFFF_FF80, 1'b0}) begin
      failures++;
      $display("FAIL byte_load_signed: ack=%b be=%b rdata=%h err=%b, required 1 1000 ffffff80 0",
               obs_ls_ack, obs_be, obs_rdata, obs_err);
    end
    i_ls_un = 1'b1;
    i_ls_req = 1'b1;
    service(2, 1'b0);
    checks++;
    if ({obs_ls_ack, obs_be, obs_rdata, obs_err} !== {1'b1, 4'b1000, 32'h0000_0080, 1'b0}) begin
      failures++;
      $display("FAIL byte_load_unsigned: ack=%b be=%b rdata=%h err=%b, required 1 1000 00000080 0",
               obs_ls_ack, obs_be, obs_rdata, obs_err);
    end
  endtask

  task automatic test_half_store();
    i_ls_wren = 1'b1; i_ls_op = 2'b10; i_ls_addr = 32'h0000_0302; i_ls_un = 1'b0;
    i_ls_wdata = 32'h1234_ABCD;
    i_ls_req = 1'b1;
    service(1, 1'b0);
    checks++;
    if ({obs_be, obs_wdata, obs_wren, obs_addr, obs_ls_ack, obs_err, obs_rdata} !==
        {4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL half_store: be=%b wdata=%h wren=%b addr=%h ack=%b err=%b rdata=%h, required 1100 abcdabcd 1 00000300 1 0 0",
               obs_be, obs_wdata, obs_wren, obs_addr, obs_ls_ack, obs_err, obs_rdata);
    end
    i_ls_addr = 32'h0000_0301;
    i_ls_req = 1'b1;
    service(1, 1'b0);
    checks++;
    if ({obs_req_cycles == 0, obs_ls_ack, obs_err} !== 3'b111) begin
      failures++;
      $display("FAIL half_store_misaligned: req_cycles=%0d ack=%b err=%b, required 0 1 1",
               obs_req_cycles, obs_ls_ack, obs_err);
    end
  endtask

  task automatic test_timeout();
    i_ls_wren = 1'b0; i_ls_op = 2'b00; i_ls_addr = 32'h0000_0040;
    i_ls_req = 1'b1;
    service(99, 1'b0);
    checks++;
    if (obs_req_cycles != TMO || !obs_stable) begin
      failures++;
      $display("FAIL timeout_req_len: req_cycles=%0d stable=%b, required %0d 1",
               obs_req_cycles, obs_stable, TMO);
    end
    checks++;
    if ({obs_ls_ack, obs_err, obs_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL timeout_resp: ack=%b err=%b rdata=%h, required 1 1 0",
               obs_ls_ack, obs_err, obs_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_ls;
    do_reset();
    exp_ls = 1'b1;
    i_ls_wren = 1'b0; i_ls_op = 2'b00; i_ls_addr = 32'h0000_0010;
    i_if_addr = 32'h0000_0020;
    i_ls_req = 1'b1;
    i_if_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      service(1, 1'b1);
      checks++;
      if (obs_ls_ack !== exp_ls || obs_if_ack !== !exp_ls) begin
        failures++;
        $display("FAIL alternation[%0d]: ls_ack=%b if_ack=%b, required ls=%b", k,
                 obs_ls_ack, obs_if_ack, exp_ls);
      end
      exp_ls = !exp_ls;
    end
    i_ls_req = 1'b0;
    i_if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    i_mem_ack = 1'b0;
    i_ls_wren = 1'b0; i_ls_op = 2'b00; i_ls_addr = 32'h0000_0008;
    i_ls_req = 1'b1;
    n = 0;
    tick();
    while (!o_mem_req && n < 8) begin
      tick();
      n++;
    end
    i_rst_n = 1'b0;
    i_ls_req = 1'b0;
    #1;
    checks++;
    if ({o_if_ack, o_if_rdata, o_if_err, o_ls_ack, o_ls_rdata, o_ls_err, o_mem_req,
         o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_be, o_busy} !== 139'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: busy=%b mem_req=%b addr=%h ls_rdata=%h, required all zero",
               o_busy, o_mem_req, o_mem_addr, o_ls_rdata);
    end
    tick();
    checks++;
    if (o_ls_ack !== 1'b0 || o_if_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_noack: ls_ack=%b if_ack=%b, required 0 0", o_ls_ack, o_if_ack);
    end
    i_rst_n = 1'b1;
    mem[0] = 32'hCAFE_F00D;
    i_if_addr = 32'h0000_0100;
    i_if_req = 1'b1;
    service(2, 1'b0);
    checks++;
    if ({obs_if_ack, obs_rdata, obs_err, obs_req_cycles == 2} !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_recover: ack=%b rdata=%h err=%b req_cycles=%0d, required 1 cafef00d 0 2",
               obs_if_ack, obs_rdata, obs_err, obs_req_cycles);
    end
  endtask

  // Randomized single-requester transactions against a spec-level model.
  task automatic test_random();
    logic [31:0] hi, full, wd, w, v, exp_rdata, exp_wd;
    logic [5:0]  a;
    logic [3:0]  exp_be;
    bit          is_ls, un, wren, mis;
    int          op, lat, exp_req;
    logic        exp_err;
    for (int t = 0; t < 60; t++) begin
      hi = $urandom(); a = 6'($urandom_range(0, 63)); full = {hi[31:6], a};
      is_ls = 1'($urandom_range(0, 1)); op = $urandom_range(0, 3);
      un = 1'($urandom_range(0, 1)); wren = 1'($urandom_range(0, 1));
      wd = $urandom(); lat = $urandom_range(1, TMO + 1);
      w = mem[a / 4];
      exp_wd = wd; exp_be = 4'b1111; exp_rdata = w;
      if (!is_ls) begin
        mis = (a % 4) != 0;
      end else if (op < 2) begin
        mis = (a % 4) != 0;
      end else if (op == 2) begin
        mis = (a % 2) != 0;
        exp_be = 4'(3 << (a & 2));
        exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        v = (w >> (8 * (a & 2))) & 32'hFFFF;
        exp_rdata = (!un && v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
      end else begin
        mis = 1'b0;
        exp_be = 4'(1 << (a & 3));
        exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        v = (w >> (8 * (a & 3))) & 32'hFF;
        exp_rdata = (!un && v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
      end
      if (is_ls && wren) exp_rdata = 32'h0;
      if (mis) begin
        exp_req = 0; exp_err = 1'b1; exp_rdata = 32'h0;
      end else if (lat > TMO) begin
        exp_req = TMO; exp_err = 1'b1; exp_rdata = 32'h0;
      end else begin
        exp_req = lat; exp_err = 1'b0;
      end
      i_if_addr = is_ls ? $urandom() : full;
      i_ls_addr = is_ls ? full : $urandom();
      i_ls_op = 2'(op); i_ls_un = un; i_ls_wren = wren; i_ls_wdata = wd;
      i_if_req = !is_ls; i_ls_req = is_ls;
      service(lat, 1'b0);
      checks++;
      if (obs_ls_ack !== is_ls || obs_if_ack !== !is_ls || obs_err !== exp_err ||
          obs_rdata !== exp_rdata || obs_req_cycles != exp_req) begin
        failures++;
        $display("FAIL rand_resp[%0d]: ls_ack=%b if_ack=%b err=%b rdata=%h req_cycles=%0d, required ls=%b err=%b rdata=%h req_cycles=%0d",
                 t, obs_ls_ack, obs_if_ack, obs_err, obs_rdata, obs_req_cycles,
                 is_ls, exp_err, exp_rdata, exp_req);
      end
      if (exp_req > 0) begin
        checks++;
        if (obs_addr !== {full[31:2], 2'b00} || obs_be !== exp_be ||
            obs_wren !== (is_ls && wren) || !obs_stable ||
            (is_ls && wren && obs_wdata !== exp_wd)) begin
          failures++;
          $display("FAIL rand_port[%0d]: addr=%h be=%b wren=%b wdata=%h stable=%b, required addr=%h be=%b wren=%b wdata=%h",
                   t, obs_addr, obs_be, obs_wren, obs_wdata, obs_stable,
                   {full[31:2], 2'b00}, exp_be, is_ls && wren, exp_wd);
        end
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_if_req = 1'b0; i_if_addr = 32'h0; i_ls_req = 1'b0;
    i_ls_wren = 1'b0; i_ls_addr = 32'h0; i_ls_wdata = 32'h0; i_ls_op = 2'b00;
    i_ls_un = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    test_reset();
    test_if_read();
    test_byte_load();
    test_half_store();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
